// File: rtl/display_scanner_pkg.sv
// display_pkg: segment decode table, anode one-hot constants and shared types for display_scanner
package display_pkg;
  typedef logic [1:0] digit_idx_t;
  typedef enum logic {BLANK, DRIVE} state_t;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [3:0][3:0] ANODE_OH = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
endpackage

// File: rtl/display_scanner_if.sv
// display_scanner_if: load/data inputs and display pin outputs of the scanner
interface display_scanner_if;
  logic        load;
  logic [15:0] values_in;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_start;
  modport master (output load, values_in, digit_en, dp_in, input seg, dp, anode, frame_start);
  modport slave  (input load, values_in, digit_en, dp_in, output seg, dp, anode, frame_start);
endinterface

// File: rtl/display_scanner_seg_decode.sv
// seg_decode: hex nibble to active-high {g,f,e,d,c,b,a} segment pattern
module seg_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[nibble_i];
endmodule

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed 4-digit 7-segment driver with dead time and frame-atomic updates
module display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic clk,
  input logic reset,
  display_scanner_if.slave dif
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};
  localparam logic [3:0] AN_INV = {4{ACTIVE_LOW}};
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  digit_idx_t digit_idx_q, digit_idx_d;
  state_t state_q, state_d;
  logic [15:0] pend_val_q, act_val_q;
  logic [3:0] pend_en_q, pend_dp_q, act_en_q, act_dp_q;
  logic pend_valid_q;
  logic [6:0] seg_q, seg_pat, seg_d;
  logic [3:0] anode_q, anode_d;
  logic dp_q, dp_d, frame_start_q, slot_end, wrap, lit;
  seg_decode u_dec (.nibble_i(act_val_q[{digit_idx_q, 2'b00} +: 4]), .seg_o(seg_pat));
  always_comb begin
    slot_end    = slot_cnt_q == SLOT_LAST;
    wrap        = slot_end && digit_idx_q == 2'd3;
    slot_cnt_d  = slot_end ? '0 : slot_cnt_q + 1'b1;
    digit_idx_d = slot_end ? digit_idx_q + 1'b1 : digit_idx_q;
    state_d     = slot_cnt_d < BLANK_END ? BLANK : DRIVE;
    lit         = state_q == DRIVE && act_en_q[digit_idx_q];
    anode_d     = lit ? ANODE_OH[digit_idx_q] : '0;
    seg_d       = lit ? seg_pat : '0;
    dp_d        = lit && act_dp_q[digit_idx_q];
  end
  // Pins are registered from state_q/digit_idx_q, so anode and seg always move on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      state_q       <= BLANK;
      pend_val_q    <= '0;
      pend_en_q     <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      act_val_q     <= '0;
      act_en_q      <= '0;
      act_dp_q      <= '0;
      seg_q         <= SEG_INV;
      anode_q       <= AN_INV;
      dp_q          <= ACTIVE_LOW;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      state_q      <= state_d;
      if (dif.load) {pend_val_q, pend_en_q, pend_dp_q} <= {dif.values_in, dif.digit_en, dif.dp_in};
      pend_valid_q <= dif.load | (pend_valid_q & ~wrap);
      if (wrap && pend_valid_q) {act_val_q, act_en_q, act_dp_q} <= {pend_val_q, pend_en_q, pend_dp_q};
      seg_q         <= seg_d ^ SEG_INV;
      anode_q       <= anode_d ^ AN_INV;
      dp_q          <= dp_d ^ ACTIVE_LOW;
      frame_start_q <= wrap;
    end
  end
  assign dif.seg         = seg_q;
  assign dif.dp          = dp_q;
  assign dif.anode       = anode_q;
  assign dif.frame_start = frame_start_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed checks of scanning, blanking, frame-atomic loads and reset (DIV=8, BLANK=2)
module tb_display_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int fails = 0;
  int mon_bad = 0;
  logic [11:0] obs [32];
  always #5 clk = ~clk;
  display_scanner_if dif ();
  display_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .dif(dif)
  );
  always @(negedge clk) begin
    if ($countones(~dif.anode) > 1) begin
      mon_bad++;
      $display("FAIL onehot: anode %b has more than one active digit", dif.anode);
    end
  end
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dif.frame_start !== 1'b1 && n < 40);
    if (dif.frame_start !== 1'b1) begin
      total++;
      fails++;
      $display("FAIL wait_fs: frame_start=%b after %0d cycles, required 1", dif.frame_start, n);
    end
  endtask
  task automatic capture();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      obs[i] = {dif.anode, dif.seg, dif.dp};
    end
  endtask
  task automatic load_vals(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d);
    dif.values_in = v;
    dif.digit_en = en;
    dif.dp_in = d;
    dif.load = 1'b1;
    @(negedge clk);
    dif.load = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({dif.anode, dif.seg, dif.dp, dif.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset: got %h, required %h", {dif.anode, dif.seg, dif.dp, dif.frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    reset = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      total++;
      if ({dif.anode, dif.seg, dif.dp} !== 12'hFFF) begin
        fails++;
        $display("FAIL idle_dark cycle %0d: got %h, required fff", n, {dif.anode, dif.seg, dif.dp});
      end
      total++;
      if (dif.frame_start !== (n % 32 == 0)) begin
        fails++;
        $display("FAIL idle_fs cycle %0d: got %b, required %b", n, dif.frame_start, n % 32 == 0);
      end
    end
  endtask
  task automatic test_load_1234();
    logic [3:0] ea [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] es [4] = '{~7'h66, ~7'h4F, ~7'h5B, ~7'h06};
    logic [11:0] exp;
    wait_fs();
    load_vals(16'h1234, 4'hF, 4'h0);
    wait_fs();
    capture();
    for (int i = 0; i < 32; i++) begin
      exp = (i % 8 < 2) ? 12'hFFF : {ea[i/8], es[i/8], 1'b1};
      total++;
      if (obs[i] !== exp) begin
        fails++;
        $display("FAIL load_1234 pos %0d: got %h, required %h", i, obs[i], exp);
      end
    end
  endtask
  task automatic test_last_wins();
    logic [3:0] ea [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] es [4] = '{~7'h71, ~7'h79, ~7'h79, ~7'h7C};
    logic [11:0] exp;
    int hits = 0;
    wait_fs();
    load_vals(16'hAAAA, 4'hF, 4'h0);
    repeat (3) @(negedge clk);
    load_vals(16'hBEEF, 4'hF, 4'h0);
    wait_fs();
    capture();
    for (int i = 0; i < 32; i++) begin
      exp = (i % 8 < 2) ? 12'hFFF : {ea[i/8], es[i/8], 1'b1};
      if (obs[i][7:1] == ~7'h77) hits++;
      total++;
      if (obs[i] !== exp) begin
        fails++;
        $display("FAIL last_wins pos %0d: got %h, required %h", i, obs[i], exp);
      end
    end
    total++;
    if (hits !== 0) begin
      fails++;
      $display("FAIL no_aaaa: 'A' pattern seen %0d cycles, required 0", hits);
    end
  endtask
  task automatic test_enable_dp();
    logic [3:0] ea [4] = '{4'hE, 4'hF, 4'hB, 4'hF};
    logic [6:0] es [4] = '{~7'h79, 7'h7F, ~7'h3F, 7'h7F};
    logic ed [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [11:0] exp;
    wait_fs();
    load_vals(16'hC0DE, 4'b0101, 4'b0001);
    wait_fs();
    capture();
    for (int i = 0; i < 32; i++) begin
      exp = (i % 8 < 2) ? 12'hFFF : {ea[i/8], es[i/8], ed[i/8]};
      total++;
      if (obs[i] !== exp) begin
        fails++;
        $display("FAIL enable_dp pos %0d: got %h, required %h", i, obs[i], exp);
      end
    end
  endtask
  task automatic test_wrap_load();
    logic [3:0] ea [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] e1 [4] = '{~7'h7F, ~7'h07, ~7'h7D, ~7'h6D};
    logic [6:0] e2 [4] = '{~7'h39, ~7'h7C, ~7'h77, ~7'h6F};
    logic [11:0] exp;
    wait_fs();
    load_vals(16'h5678, 4'hF, 4'h0);
    repeat (30) @(negedge clk);
    dif.values_in = 16'h9ABC;
    dif.load = 1'b1;
    @(negedge clk);
    dif.load = 1'b0;
    total++;
    if (dif.frame_start !== 1'b1) begin
      fails++;
      $display("FAIL wrap_fs: frame_start=%b on load edge, required 1", dif.frame_start);
    end
    capture();
    for (int i = 0; i < 32; i++) begin
      exp = (i % 8 < 2) ? 12'hFFF : {ea[i/8], e1[i/8], 1'b1};
      total++;
      if (obs[i] !== exp) begin
        fails++;
        $display("FAIL wrap_old pos %0d: got %h, required %h", i, obs[i], exp);
      end
    end
    wait_fs();
    capture();
    for (int i = 0; i < 32; i++) begin
      exp = (i % 8 < 2) ? 12'hFFF : {ea[i/8], e2[i/8], 1'b1};
      total++;
      if (obs[i] !== exp) begin
        fails++;
        $display("FAIL wrap_new pos %0d: got %h, required %h", i, obs[i], exp);
      end
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    wait_fs();
    repeat (20) @(negedge clk);
    total++;
    if ({dif.anode, dif.seg} !== {4'b1011, ~7'h77}) begin
      fails++;
      $display("FAIL mid_drive: got %h, required %h", {dif.anode, dif.seg}, {4'b1011, ~7'h77});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({dif.anode, dif.seg, dif.dp, dif.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: got %h, required %h", {dif.anode, dif.seg, dif.dp, dif.frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    do begin
      @(negedge clk);
      n++;
    end while (dif.frame_start !== 1'b1 && n < 40);
    total++;
    if (n !== 32) begin
      fails++;
      $display("FAIL reset_idx: first frame_start after %0d cycles, required 32", n);
    end
    total++;
    if ({dif.anode, dif.seg, dif.dp} !== 12'hFFF) begin
      fails++;
      $display("FAIL reset_cleared: got %h, required fff", {dif.anode, dif.seg, dif.dp});
    end
  endtask
  initial begin
    dif.load = 1'b0;
    dif.values_in = '0;
    dif.digit_en = '0;
    dif.dp_in = '0;
    test_reset();
    test_load_1234();
    test_last_wins();
    test_enable_dp();
    test_wrap_load();
    test_reset_mid();
    total++;
    if (mon_bad !== 0) begin
      fails++;
      $display("FAIL onehot_total: %0d violating cycles, required 0", mon_bad);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
